// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore-FSM controller for a shared multi-cycle MIPS datapath
module mips_multicycle_ctrl #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic                busy,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t                state;
    state_t                next_state;
    logic                  inst_end;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  illegal_q;

    // State register; reset parks the FSM in IDLE immediately, even mid-instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; inst_end marks the final cycle of a retiring instruction
    always_comb begin
        next_state = state;
        inst_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_REXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    next_state = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: inst_end = 1'b1;
            S_MEMWR: begin
                if (mem_ready) begin
                    inst_end = 1'b1;
                end
            end
            S_REXEC: next_state = S_RWB;
            S_RWB:   inst_end = 1'b1;
            S_BEQ:   inst_end = 1'b1;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
        if (inst_end) begin
            next_state = run ? S_FETCH : S_IDLE;
        end
    end

    // Retirement counter (wrapping) and sticky trap flag; both frozen once in TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (inst_end) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Per-state control strobes; only the FETCH capture strobes look at mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state != S_IDLE) && (state != S_TRAP);
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state;

endmodule
